// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: assembles MSB-first words from a valid-qualified
// bit stream and buffers them in a first-word fall-through FIFO.
module s2p_rx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data,
  input  logic                     vld,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_vld,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     frm_err,
  output logic                     ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

  typedef enum logic {
    StIdle,
    StRecv
  } state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frm_err;
  logic             r_ovf;
  logic [LW-1:0]    r_level;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;

  // Word as it stands after shifting in the current bit.
  assign w_word = {r_shift[WIDTH-2:0], data};
  assign w_push = vld && (r_cnt == CntLast);
  assign w_pop  = rd && (r_level != '0);
  assign w_full = (r_level == LvlFull);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_frm_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (vld) begin
            r_shift <= w_word;
            r_cnt   <= CW'(1);
            r_state <= StRecv;
          end
        end
        StRecv: begin
          if (!vld) begin
            r_frm_err <= 1'b1;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_state   <= StIdle;
          end else if (w_push) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= StIdle;
          end else begin
            r_shift <= w_word;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_shift <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_wr && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_wr && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      if (w_push && !w_wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign dout     = (r_level != '0) ? r_mem[r_rptr] : '0;
  assign dout_vld = (r_level != '0);
  assign level    = r_level;
  assign full     = w_full;
  assign frm_err  = r_frm_err;
  assign ovf      = r_ovf;

endmodule

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bits per word and match the upstream p2s parallel width.
REQ-002 Parameter DEPTH, default 4, SHALL set the output FIFO depth in words and SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 data  input  1  SHALL be the serial bit from p2s, qualified by vld.
REQ-006 vld  input  1  SHALL be the serial bit-valid from p2s; one bit per cycle while high.
REQ-007 rd  input  1  SHALL be the pop request for the FIFO head word.
REQ-008 dout  output  WIDTH  SHALL be the FIFO head word (first-word fall-through).
REQ-009 dout_vld  output  1  SHALL be high while the FIFO is non-empty.
REQ-010 level  output  $clog2(DEPTH)+1  SHALL be the number of words held.
REQ-011 full  output  1  SHALL be high when level == DEPTH.
REQ-012 frm_err  output  1  SHALL be a one-cycle pulse flagging a truncated word.
REQ-013 ovf  output  1  SHALL be a sticky flag set when a completed word is dropped because the FIFO is full.

Function
REQ-014 Each rising edge with vld=1 SHALL sample exactly one bit, MSB first; the first bit of a word lands in bit WIDTH-1.
REQ-015 A bit counter cnt (0..WIDTH-1) SHALL increment per sampled bit and wrap to 0 on the WIDTH-th bit.
REQ-016 FSM SHALL have two states: IDLE (cnt==0) and RECV (0<cnt<WIDTH). IDLE->RECV on the first valid bit. RECV->IDLE on word completion or on vld=0.
REQ-017 On the edge sampling the WIDTH-th bit, the assembled word (shift register plus current bit) SHALL be pushed into the FIFO on that same edge.
REQ-018 The pushed word SHALL appear on dout, with dout_vld=1, in the cycle immediately after that edge if the FIFO was empty; latency is 1 cycle from the last bit.
REQ-019 Back-to-back words, with vld held high for k*WIDTH cycles, SHALL be received with no gap cycles required.
REQ-020 When vld is low in RECV (cnt!=0), the partial word SHALL be discarded, cnt cleared, no push made, and frm_err asserted for exactly the next cycle.
REQ-021 When vld is low in IDLE, the block SHALL hold state with no error.
REQ-022 rd=1 with dout_vld=1 SHALL pop the head on that edge. rd=1 while empty SHALL be ignored, with no underflow and level unchanged.
REQ-023 A push and a pop on the same edge SHALL both take effect with level unchanged, including when full: no drop and no ovf.
REQ-024 A push while full without a simultaneous pop SHALL drop the new word, leave the FIFO contents intact, and set ovf until reset.
REQ-025 FIFO read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL never exceed DEPTH.
REQ-026 Outputs SHALL be driven from registers or from FIFO storage indexed by a registered pointer; they SHALL have no combinational path from data or vld.

Reset
REQ-027 While rst=1, the block SHALL hold cnt=0, state=IDLE, shift register=0, pointers=0, level=0, dout=0, dout_vld=0, full=0, frm_err=0 and ovf=0, independent of clk.
REQ-028 Reset asserted mid-word SHALL discard the partial word and all FIFO contents; the first valid bit after release SHALL be treated as an MSB.
REQ-029 Sampling SHALL start on the first rising edge after rst deasserts.

Verification
REQ-030 The bench SHALL apply data=1,0,0,1 with vld=1 for 4 cycles and then vld=0, and SHALL require dout=4'b1001, dout_vld=1 and level=1 in the cycle after the 4th bit, with frm_err=0.
REQ-031 The bench SHALL hold vld high for 8 cycles carrying 1001 then 0110, and SHALL require level=2, dout=1001, and after one rd, dout=0110.
REQ-032 The bench SHALL send 2 bits (1,1) and then vld=0, and SHALL require frm_err=1 for one cycle and level=0; a following 0011 SHALL then be received as 4'b0011.
REQ-033 The bench SHALL push 4 words with rd=0 and then a 5th word 4'b1111, and SHALL require full=1, ovf=1, level=4, and the first 4 words popped in order with 1111 absent.
REQ-034 The bench SHALL complete a 5th word with rd=1 on the same edge while full, and SHALL require ovf=0, level=4, and the oldest word removed.
REQ-035 The bench SHALL assert rst after 2 bits of a word and then send 1010, and SHALL require all outputs zero during reset and dout=4'b1010 after the word.
